// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: DIGITS-digit BCD modulo-MODULUS up/down counter with IDLE/RUN/HOLD control.
// Optional display freeze (lap) is built only when BCD_CNT_LAP_EN is defined.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk_1s,
  input  logic                clr_n,
  input  logic                start,
  input  logic                stay,
  input  logic                dir,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] disp,
  output logic                carry,
  output logic                borrow,
  output logic                running,
  output logic                load_err
);
  localparam int W = 4 * DIGITS;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic logic [W+3:0] to_bcd(input int v);
    logic [W+3:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k <= DIGITS; k++) begin
      r[4*k+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One extra digit so MODULUS = 10^DIGITS is representable for the preset range check
  localparam logic [W+3:0] MOD_BCD = to_bcd(MODULUS);
  localparam logic [W+3:0] TOP_EXT = to_bcd(MODULUS - 1);
  localparam logic [W-1:0] TOP     = TOP_EXT[W-1:0];

  logic [1:0]   r_state;
  logic [W-1:0] r_count;
  logic         r_carry;
  logic         r_borrow;
  logic         r_running;
  logic         r_lerr;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_ci;
  logic         w_bi;
  logic         w_dig_ok;
  logic         w_ld_ok;
  logic         w_tick;
  logic [W-1:0] w_cnt_nxt;
  logic [1:0]   w_state_nxt;

  always_comb begin
    w_inc    = r_count;
    w_dec    = r_count;
    w_ci     = 1'b1;
    w_bi     = 1'b1;
    w_dig_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_inc[4*k+:4] = w_ci ? (r_count[4*k+:4] == 4'd9 ? 4'd0 : r_count[4*k+:4] + 4'd1) : r_count[4*k+:4];
      w_dec[4*k+:4] = w_bi ? (r_count[4*k+:4] == 4'd0 ? 4'd9 : r_count[4*k+:4] - 4'd1) : r_count[4*k+:4];
      w_ci     = w_ci && r_count[4*k+:4] == 4'd9;
      w_bi     = w_bi && r_count[4*k+:4] == 4'd0;
      w_dig_ok = w_dig_ok && load_val[4*k+:4] <= 4'd9;
    end
  end

  // With every digit legal, BCD order equals numeric order, so a plain compare suffices
  assign w_ld_ok   = load && w_dig_ok && ({4'd0, load_val} < MOD_BCD);
  assign w_tick    = r_state == RUN && !stay && !load;
  assign w_cnt_nxt = w_ld_ok ? load_val :
                     !w_tick ? r_count :
                     dir     ? (r_count == '0 ? TOP : w_dec) :
                               (r_count == TOP ? '0 : w_inc);

  always_comb begin
    w_state_nxt = load              ? r_state :
                  r_state == IDLE   ? (start && !stay ? RUN : IDLE) :
                  r_state == RUN    ? (stay ? HOLD : RUN) :
                  r_state == HOLD   ? (stay ? HOLD : RUN) : IDLE;
  end

  always_ff @(posedge clk_1s or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_running <= 1'b0;
      r_lerr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_cnt_nxt;
      r_carry   <= w_tick && !dir && r_count == TOP;
      r_borrow  <= w_tick && dir && r_count == '0;
      r_running <= w_state_nxt == RUN;
      r_lerr    <= load && !w_ld_ok;
    end
  end

  assign count    = r_count;
  assign carry    = r_carry;
  assign borrow   = r_borrow;
  assign running  = r_running;
  assign load_err = r_lerr;

`ifdef BCD_CNT_LAP_EN
  logic         r_frz;
  logic [W-1:0] r_disp;
  logic         w_frz_nxt;

  assign w_frz_nxt = w_ld_ok ? 1'b0 : r_frz ^ lap;

  // Display was tracking count up to the freeze edge, so holding it captures that edge's count
  always_ff @(posedge clk_1s or negedge clr_n) begin
    if (!clr_n) begin
      r_frz  <= 1'b0;
      r_disp <= '0;
    end else begin
      r_frz  <= w_frz_nxt;
      r_disp <= w_frz_nxt ? r_disp : w_cnt_nxt;
    end
  end

  assign disp = r_disp;
`else
  logic w_unused_lap;

  assign w_unused_lap = lap;
  assign disp         = r_count;
`endif
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: table, directed and randomized checks of bcd_mod_counter against a behavioural model.
module tb_bcd_mod_counter;
  logic        clk_1s = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic        stay = 1'b0;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic        lap = 1'b0;
  logic [7:0]  load_val = '0;
  logic [7:0]  count;
  logic [7:0]  disp;
  logic        carry;
  logic        borrow;
  logic        running;
  logic        load_err;
  logic        clr3_n = 1'b0;
  logic        start3 = 1'b0;
  logic        load3 = 1'b0;
  logic [11:0] lv3 = '0;
  logic [11:0] count3;
  logic [11:0] disp3;
  logic        carry3;
  logic        borrow3;
  logic        run3;
  logic        lerr3;
  int          n_pass = 0;
  int          n_tot = 0;
  int          m_cnt;
  int          m_disp;
  int          m_st;
  bit          m_carry;
  bit          m_borrow;
  bit          m_lerr;
  bit          m_frz;

  typedef struct {
    bit         ld;
    logic [7:0] lv;
    bit         st;
    bit         sy;
    bit         dr;
    logic [7:0] ec;
    bit         eca;
    bit         ebo;
    bit         eru;
    bit         ele;
  } vec_t;

  vec_t tv[16];

  bcd_mod_counter u_dut (
    .clk_1s(clk_1s), .clr_n(clr_n), .start(start), .stay(stay), .dir(dir),
    .load(load), .load_val(load_val), .lap(lap), .count(count), .disp(disp),
    .carry(carry), .borrow(borrow), .running(running), .load_err(load_err)
  );

  bcd_mod_counter #(.DIGITS(3), .MODULUS(24)) u_d3 (
    .clk_1s(clk_1s), .clr_n(clr3_n), .start(start3), .stay(1'b0), .dir(1'b0),
    .load(load3), .load_val(lv3), .lap(1'b0), .count(count3), .disp(disp3),
    .carry(carry3), .borrow(borrow3), .running(run3), .load_err(lerr3)
  );

  always #5 clk_1s = ~clk_1s;

  function automatic bit valid2(input logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction

  function automatic int bin2(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_edge();
    bit ok;
    bit tk;
    ok = load && valid2(load_val) && bin2(load_val) < 60;
    tk = m_st == 1 && !stay && !load;
    m_carry  = tk && !dir && m_cnt == 59;
    m_borrow = tk && dir && m_cnt == 0;
    m_lerr   = load && !ok;
    if (ok) m_cnt = bin2(load_val);
    else if (tk) m_cnt = (m_cnt + (dir ? 59 : 1)) % 60;
    if (!load) m_st = m_st == 0 ? ((start && !stay) ? 1 : 0) : (stay ? 2 : 1);
`ifdef BCD_CNT_LAP_EN
    if (ok) m_frz = 1'b0;
    else if (lap) m_frz = !m_frz;
    if (!m_frz) m_disp = m_cnt;
`else
    m_disp = m_cnt;
`endif
  endtask

  task automatic check_model(input string tag);
    check({tag, " count"}, int'(count), int'(bcd2(m_cnt)));
    check({tag, " disp"}, int'(disp), int'(bcd2(m_disp)));
    check({tag, " carry"}, int'(carry), int'(m_carry));
    check({tag, " borrow"}, int'(borrow), int'(m_borrow));
    check({tag, " running"}, int'(running), m_st == 1 ? 1 : 0);
    check({tag, " load_err"}, int'(load_err), int'(m_lerr));
  endtask

  task automatic step();
    @(posedge clk_1s);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #1;
    m_cnt = 0; m_disp = 0; m_st = 0;
    m_carry = 1'b0; m_borrow = 1'b0; m_lerr = 1'b0; m_frz = 1'b0;
    check_model("reset");
    #2 clr_n = 1'b1;
  endtask

  task automatic chk3(input string tag, input logic [11:0] ec, input bit eca, input bit eru, input bit ele);
    check({tag, " count3"}, int'(count3), int'(ec));
    check({tag, " disp3"}, int'(disp3), int'(ec));
    check({tag, " carry3"}, int'(carry3), int'(eca));
    check({tag, " running3"}, int'(run3), int'(eru));
    check({tag, " load_err3"}, int'(lerr3), int'(ele));
  endtask

  task automatic step3(input string tag, input logic [11:0] ec, input bit eca, input bit eru, input bit ele);
    @(posedge clk_1s);
    #1;
    chk3(tag, ec, eca, eru, ele);
  endtask

  initial begin
    int ncar;
    int car_val;
    tv[0]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    tv[1]  = '{1, 8'h45, 0, 0, 0, 8'h45, 0, 0, 1, 0};
    tv[2]  = '{0, 8'h00, 0, 0, 0, 8'h46, 0, 0, 1, 0};
    tv[3]  = '{1, 8'h60, 0, 0, 0, 8'h46, 0, 0, 1, 1};
    tv[4]  = '{1, 8'h3A, 0, 0, 0, 8'h46, 0, 0, 1, 1};
    tv[5]  = '{0, 8'h00, 0, 0, 0, 8'h47, 0, 0, 1, 0};
    tv[6]  = '{1, 8'h59, 0, 0, 0, 8'h59, 0, 0, 1, 0};
    tv[7]  = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 0};
    tv[8]  = '{0, 8'h00, 0, 0, 1, 8'h59, 0, 1, 1, 0};
    tv[9]  = '{0, 8'h00, 0, 0, 1, 8'h58, 0, 0, 1, 0};
    tv[10] = '{0, 8'h00, 0, 0, 0, 8'h59, 0, 0, 1, 0};
    tv[11] = '{0, 8'h00, 0, 1, 0, 8'h59, 0, 0, 0, 0};
    tv[12] = '{0, 8'h00, 0, 1, 0, 8'h59, 0, 0, 0, 0};
    tv[13] = '{0, 8'h00, 0, 0, 0, 8'h59, 0, 0, 1, 0};
    tv[14] = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 0};
    tv[15] = '{0, 8'h00, 1, 0, 0, 8'h01, 0, 0, 1, 0};
    #1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      load = tv[i].ld; load_val = tv[i].lv; start = tv[i].st; stay = tv[i].sy; dir = tv[i].dr;
      step();
      check($sformatf("vec%0d count", i), int'(count), int'(tv[i].ec));
      check($sformatf("vec%0d disp", i), int'(disp), int'(tv[i].ec));
      check($sformatf("vec%0d carry", i), int'(carry), int'(tv[i].eca));
      check($sformatf("vec%0d borrow", i), int'(borrow), int'(tv[i].ebo));
      check($sformatf("vec%0d running", i), int'(running), int'(tv[i].eru));
      check($sformatf("vec%0d load_err", i), int'(load_err), int'(tv[i].ele));
    end
    start = 1'b0; dir = 1'b0;
    load = 1'b1; load_val = 8'h17;
    step();
    check("hold preset", int'(count), 'h17);
    load = 1'b0; stay = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold count", int'(count), 'h17);
      check("hold running", int'(running), 0);
      check_model("hold");
    end
    stay = 1'b0;
    step();
    check("resume count", int'(count), 'h17);
    check("resume running", int'(running), 1);
    step();
    check("resume next", int'(count), 'h18);
    check_model("resume");
    do_reset();
    start = 1'b1;
    step();
    check_model("sweep start");
    start = 1'b0;
    ncar = 0;
    car_val = -1;
    for (int i = 0; i < 69; i++) begin
      step();
      check_model("sweep");
      if (carry) begin
        ncar++;
        car_val = int'(count);
      end
    end
    check("sweep final", int'(count), 'h09);
    check("sweep carries", ncar, 1);
    check("sweep carry_at", car_val, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-reset idle count", int'(count), 0);
      check_model("post-reset idle");
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("restart count", int'(count), 'h01);
`ifdef BCD_CNT_LAP_EN
    do_reset();
    load = 1'b1; load_val = 8'h30;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; lap = 1'b1;
    step();
    lap = 1'b0;
    check("lap freeze disp", int'(disp), 'h30);
    check("lap freeze count", int'(count), 'h31);
    for (int i = 0; i < 4; i++) begin
      step();
      check("lap held disp", int'(disp), 'h30);
      check_model("lap held");
    end
    check("lap count 35", int'(count), 'h35);
    lap = 1'b1;
    step();
    lap = 1'b0;
    check("lap release disp", int'(disp), 'h36);
    step();
    check("lap track disp", int'(disp), 'h37);
    check_model("lap track");
`else
    lap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_model("lap ignored");
    end
    lap = 1'b0;
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
        continue;
      end
      load     = $urandom_range(7) == 0;
      load_val = $urandom_range(3) == 0 ? 8'($urandom_range(255)) : bcd2($urandom_range(59));
      start    = $urandom_range(3) == 0;
      stay     = $urandom_range(4) == 0;
      dir      = 1'($urandom_range(1));
      lap      = $urandom_range(5) == 0;
      step();
      check_model($sformatf("rand%0d", i));
    end
    load = 1'b0; start = 1'b0; stay = 1'b0; lap = 1'b0;
    #1;
    chk3("d3 reset", 12'h000, 0, 0, 0);
    clr3_n = 1'b1;
    load3 = 1'b1; lv3 = 12'h023;
    step3("d3 preset", 12'h023, 0, 0, 0);
    load3 = 1'b0; start3 = 1'b1;
    step3("d3 start", 12'h023, 0, 1, 0);
    start3 = 1'b0;
    step3("d3 wrap", 12'h000, 1, 1, 0);
    step3("d3 001", 12'h001, 0, 1, 0);
    load3 = 1'b1; lv3 = 12'h024;
    step3("d3 bad preset", 12'h001, 0, 1, 1);
    load3 = 1'b0;
    step3("d3 002", 12'h002, 0, 1, 0);
    #2 clr3_n = 1'b0;
    #1;
    chk3("d3 midrun reset", 12'h000, 0, 0, 0);
    #1 clr3_n = 1'b1;
    for (int i = 0; i < 3; i++) step3("d3 idle", 12'h000, 0, 0, 0);
    start3 = 1'b1;
    step3("d3 restart", 12'h000, 0, 1, 0);
    start3 = 1'b0;
    step3("d3 count", 12'h001, 0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 The block SHALL have the parameter DIGITS, default 2, giving the number of BCD digits; the legal range is 1..4.
REQ-002 The block SHALL have the parameter MODULUS, default 60, giving the count modulus; the legal range is 2..10^DIGITS.
REQ-003 clk_1s  input  1  single clock; the count advances on its rising edge.
REQ-004 clr_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  run request, sampled on rising clk_1s.
REQ-006 stay  input  1  hold request, level-sensitive, sampled synchronously.
REQ-007 dir  input  1  count direction; 0 = up, 1 = down.
REQ-008 load  input  1  synchronous preset strobe.
REQ-009 load_val  input  4*DIGITS  preset value in BCD; the least significant digit is in [3:0].
REQ-010 lap  input  1  display-freeze toggle; used only when BCD_CNT_LAP_EN is defined.
REQ-011 count  output  4*DIGITS  live BCD count, registered.
REQ-012 disp  output  4*DIGITS  display value, registered.
REQ-013 carry  output  1  one-cycle pulse on an up-count wrap.
REQ-014 borrow  output  1  one-cycle pulse on a down-count wrap.
REQ-015 running  output  1  high while the FSM is in RUN.
REQ-016 load_err  output  1  one-cycle pulse when a preset is rejected.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-018 FSM transitions SHALL be:
- IDLE->RUN when start=1 and stay=0.
- RUN->HOLD when stay=1.
- HOLD->RUN when stay=0.
- No other transitions; start is ignored outside IDLE.
REQ-019 In RUN, count SHALL change by exactly 1 per clk_1s edge, with decimal carry between digits.
- No digit SHALL ever hold a value above 9.
REQ-020 Up-count wrap: count SHALL go from MODULUS-1 to 0.
- carry SHALL be 1 in the cycle in which count shows 0.
- carry SHALL be 0 in every other cycle.
REQ-021 Down-count wrap: count SHALL go from 0 to MODULUS-1.
- borrow SHALL pulse in the same cycle as the wrap.
REQ-022 In IDLE and HOLD, count SHALL stay unchanged, and carry and borrow SHALL stay 0.
REQ-023 A load accept SHALL occur when load=1, every digit of load_val is 9 or less, and its value is below MODULUS.
- It SHALL be honoured in any state.
- count SHALL equal load_val after the next edge.
- The state SHALL be unchanged, and no counting SHALL happen that cycle.
REQ-024 A load with an invalid load_val SHALL leave count unchanged and pulse load_err for one cycle.
REQ-025 Update priority SHALL be: reset > load > HOLD/IDLE > count.
REQ-026 A change of dir SHALL take effect on the next RUN edge, with no skipped or repeated values.
REQ-027 Latency: input to output SHALL be one clk_1s edge for every registered output.
REQ-028 running SHALL be a registered decode of state==RUN.

Reset
REQ-029 While clr_n=0, the following SHALL hold immediately, with no clock required:
- state=IDLE, count=0, disp=0.
- carry=0, borrow=0, load_err=0, running=0.
- lap-freeze flag cleared.
REQ-030 Reset asserted mid-count SHALL abort counting.
- After release, counting SHALL resume only after a new start.
REQ-031 The first clk_1s edge after clr_n rises SHALL be a normal functional edge.

Configuration
REQ-032 With BCD_CNT_LAP_EN defined:
- Each cycle with lap=1 SHALL toggle a freeze flag.
- On entering freeze, disp SHALL capture the count value of that edge and hold it while counting continues.
- On leaving freeze, disp SHALL track count again from the next edge.
- An accepted load SHALL clear the freeze flag.
REQ-033 With BCD_CNT_LAP_EN undefined:
- The lap input SHALL be ignored and no freeze logic SHALL be present.
- disp SHALL equal count at all times.

Verification
REQ-034 Default params, reset, start, dir=0, 70 edges -> count steps 00..59, then 00..09; carry high only at the 59->00 edge.
REQ-035 dir=1 from 00 -> count 59, borrow=1 for one cycle; the next edge gives 58.
REQ-036 load_val=8'h45 -> count=45; load_val=8'h60 or 8'h3A -> count unchanged, load_err pulses once.
REQ-037 stay=1 for 5 edges at count 17 -> count stays 17, running=0; stay=0 -> 18 on the next edge.
REQ-038 DIGITS=3, MODULUS=24, up at 23 -> 000 with carry; clr_n low mid-run -> count 000, IDLE, no counting until start.
REQ-039 Lap enabled: lap pulse at count 30 -> disp holds 30 while count reaches 35; second lap pulse -> disp=36 on the following edge.
